// File: rtl/gate_pkg.sv
// Shared gate-select encodings and the per-bit gate function used by the
// gate_array_pipe datapath.
package gate_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    // Upper bound on lane count; a column of one bit from every lane is evaluated at a time.
    localparam int MAX_N = 16;

    function automatic logic gate_eval(input logic [2:0] op, input logic [MAX_N-1:0] lanes,
                                       input int n_in);
        logic all1;
        logic any1;
        logic par;
        logic r;
        all1 = 1'b1;
        any1 = 1'b0;
        par  = 1'b0;
        for (int k = 0; k < MAX_N; k++) begin
            if (k < n_in) begin
                all1 = all1 & lanes[k];
                any1 = any1 | lanes[k];
                par  = par ^ lanes[k];
            end
        end
        case (op)
            OP_AND:  r = all1;
            OP_NAND: r = !all1;
            OP_OR:   r = any1;
            OP_NOR:  r = !any1;
            OP_XOR:  r = par;
            OP_XNOR: r = !par;
            OP_NOT:  r = !lanes[0];
            default: r = lanes[0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_pipe_stage.sv
// One elastic pipeline register holding {valid, op, data}; loads when empty
// or when the downstream stage frees this cycle.
module gate_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_vld,
    input  logic [2:0]       up_op,
    input  logic [WIDTH-1:0] up_data,
    input  logic             ready_in,
    output logic             ready_out,
    output logic             vld,
    output logic [2:0]       op,
    output logic [WIDTH-1:0] data
);

    assign ready_out = !vld || ready_in;

    // An empty upstream slot only clears valid; payload is kept so a stall never disturbs it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld  <= 1'b0;
            op   <= 3'd0;
            data <= '0;
        end else if (ready_out) begin
            vld <= up_vld;
            if (up_vld) begin
                op   <= up_op;
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/gate_array_pipe.sv
// Bitwise gate across N_IN lanes, evaluated at the input and carried through
// STAGES valid/ready registers, plus a wrapping output-transfer counter.
module gate_array_pipe
    import gate_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int N_IN   = 2,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_op,
    input  logic [N_IN*WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [2:0]            out_op,
    output logic [CNT_W-1:0]      xfer_count
);

    logic [WIDTH-1:0]             eval_p0;
    logic [STAGES:0]              vld_c;
    logic [STAGES:0][2:0]         op_c;
    logic [STAGES:0][WIDTH-1:0]   data_c;

    // Input side: gather bit b of every lane into one column and reduce it.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [MAX_N-1:0] col;
        for (genvar k = 0; k < MAX_N; k++) begin : g_lane
            if (k < N_IN) begin : g_used
                assign col[k] = in_data[k*WIDTH+b];
            end else begin : g_pad
                assign col[k] = 1'b0;
            end
        end
        assign eval_p0[b] = gate_eval(in_op, col, N_IN);
    end

    assign vld_c[0]  = in_valid;
    assign op_c[0]   = in_op;
    assign data_c[0] = eval_p0;

    // Stage chain: ready ripples back through one scope per stage so each link is its own net.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic rdy_up;
        logic rdy_dn;
        if (k == STAGES - 1) begin : g_last
            assign rdy_dn = out_ready;
        end else begin : g_mid
            assign rdy_dn = g_stage[k+1].rdy_up;
        end
        gate_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .up_vld    (vld_c[k]),
            .up_op     (op_c[k]),
            .up_data   (data_c[k]),
            .ready_in  (rdy_dn),
            .ready_out (rdy_up),
            .vld       (vld_c[k+1]),
            .op        (op_c[k+1]),
            .data      (data_c[k+1])
        );
    end

    assign in_ready  = g_stage[0].rdy_up;
    assign out_valid = vld_c[STAGES];
    assign out_op    = op_c[STAGES];
    assign out_data  = data_c[STAGES];

    // Output side: count completed transfers, wrapping naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_count <= '0;
        end else if (out_valid && out_ready) begin
            xfer_count <= xfer_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_gate_array_pipe.sv
// Bench for gate_array_pipe: three configurations, a queue-based reference
// model checked every cycle, and directed vectors with literal expectations.
module tb_gate_array_pipe;
    import gate_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    // A: WIDTH=1 N_IN=2 STAGES=1
    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
    logic [2:0]  a_in_op = 3'd0, a_out_op;
    logic [1:0]  a_in_data = 2'd0;
    logic [0:0]  a_out_data;
    logic [15:0] a_xfer;
    // B: WIDTH=8 N_IN=3 STAGES=2
    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
    logic [2:0]  b_in_op = 3'd0, b_out_op;
    logic [23:0] b_in_data = 24'd0;
    logic [7:0]  b_out_data;
    logic [15:0] b_xfer;
    // C: WIDTH=8 N_IN=3 STAGES=3 CNT_W=4
    logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b0;
    logic [2:0]  c_in_op = 3'd0, c_out_op;
    logic [23:0] c_in_data = 24'd0;
    logic [7:0]  c_out_data;
    logic [3:0]  c_xfer;

    gate_array_pipe #(.WIDTH(1), .N_IN(2), .STAGES(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_op(a_in_op),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_op(a_out_op), .xfer_count(a_xfer));
    gate_array_pipe #(.WIDTH(8), .N_IN(3), .STAGES(2), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_op(b_out_op), .xfer_count(b_xfer));
    gate_array_pipe #(.WIDTH(8), .N_IN(3), .STAGES(3), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_op(c_in_op),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .out_op(c_out_op), .xfer_count(c_xfer));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: per-DUT FIFO of expected beats, each stamped with its acceptance edge.
    typedef struct {
        logic [2:0] op;
        logic [7:0] data;
        int         stamp;
    } ent_t;

    ent_t  mq [3][$];
    int    mcnt [3]  = '{0, 0, 0};
    int    stg [3]   = '{1, 2, 3};
    int    nlane [3] = '{2, 3, 3};
    int    wid [3]   = '{1, 8, 8};
    int    cmask [3] = '{32'hFFFF, 32'hFFFF, 32'hF};
    string tag [3]   = '{"A", "B", "C"};
    int    cyc = 0;

    function automatic logic [7:0] model_gate(input logic [2:0] op, input logic [23:0] dat,
                                              input int n, input int w);
        logic [7:0]       r;
        logic [MAX_N-1:0] col;
        r = '0;
        for (int b = 0; b < w; b++) begin
            col = '0;
            for (int k = 0; k < n; k++) col[k] = dat[k*w+b];
            r[b] = gate_eval(op, col, n);
        end
        return r;
    endfunction

    task automatic model_step(input int d, input logic iv, input logic ir, input logic [2:0] iop,
                              input logic [23:0] idat, input logic ov, input logic orr,
                              input logic [2:0] oop, input logic [7:0] odat,
                              input logic [15:0] xc);
        ent_t e;
        logic exp_ov;
        logic exp_ir;
        if (rst) begin
            mq[d].delete();
            mcnt[d] = 0;
            chk({tag[d], " rst out_valid"}, ov, 0);
            chk({tag[d], " rst out_data"}, odat, 0);
            chk({tag[d], " rst out_op"}, oop, 0);
            chk({tag[d], " rst xfer_count"}, xc, 0);
            chk({tag[d], " rst in_ready"}, ir, 1);
            return;
        end
        exp_ov = (mq[d].size() > 0) && ((cyc - mq[d][0].stamp) >= stg[d] - 1);
        exp_ir = !((mq[d].size() == stg[d]) && !orr);
        chk({tag[d], " out_valid"}, ov, exp_ov);
        chk({tag[d], " in_ready"}, ir, exp_ir);
        chk({tag[d], " xfer_count"}, xc, mcnt[d] & cmask[d]);
        if (ov === 1'b1 && mq[d].size() > 0) begin
            chk({tag[d], " out_data"}, odat, mq[d][0].data);
            chk({tag[d], " out_op"}, oop, mq[d][0].op);
        end
        if (ov === 1'b1 && orr && mq[d].size() > 0) begin
            void'(mq[d].pop_front());
            mcnt[d]++;
        end
        if (iv && ir === 1'b1) begin
            e.op    = iop;
            e.data  = model_gate(iop, idat, nlane[d], wid[d]);
            e.stamp = cyc + 1;
            mq[d].push_back(e);
        end
    endtask

    // Compare process: inputs are stable at the falling edge, so this also predicts the next rise.
    always @(negedge clk) begin
        model_step(0, a_in_valid, a_in_ready, a_in_op, {22'd0, a_in_data}, a_out_valid,
                   a_out_ready, a_out_op, {7'd0, a_out_data}, a_xfer);
        model_step(1, b_in_valid, b_in_ready, b_in_op, b_in_data, b_out_valid,
                   b_out_ready, b_out_op, b_out_data, b_xfer);
        model_step(2, c_in_valid, c_in_ready, c_in_op, c_in_data, c_out_valid,
                   c_out_ready, c_out_op, c_out_data, {12'd0, c_xfer});
        cyc++;
    end

    logic [1:0] t1_in [4]  = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic       t1_exp [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] t2_exp [8] = '{8'h30, 8'hCF, 8'hFF, 8'h00, 8'h33, 8'hCC, 8'h00, 8'hFF};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  sent;
        int  budget;
        logic fired;

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset b_out_valid", b_out_valid, 0);
        chk("reset b_in_ready", b_in_ready, 1);
        chk("reset c_xfer", c_xfer, 0);

        // Single-bit NAND, one cycle latency
        a_out_ready = 1'b1;
        a_in_op     = OP_NAND;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = t1_in[i];
            @(posedge clk); #1;
            chk("t1 nand valid", a_out_valid, 1);
            chk("t1 nand data", a_out_data, t1_exp[i]);
        end
        a_in_valid = 1'b0;

        // All eight ops on lanes FF,F0,3C
        b_out_ready = 1'b1;
        for (int j = 0; j <= 8; j++) begin
            if (j < 8) begin
                b_in_valid = 1'b1;
                b_in_op    = 3'(j);
                b_in_data  = 24'h3CF0FF;
            end else begin
                b_in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (j >= 1) begin
                chk("t2 valid", b_out_valid, 1);
                chk("t2 data", b_out_data, t2_exp[j-1]);
                chk("t2 op", b_out_op, 32'(j - 1));
            end
        end
        @(posedge clk); #1;

        // Backpressure: two beats fit, the third waits
        b_out_ready = 1'b0;
        b_in_op     = OP_PASS;
        b_in_valid  = 1'b1;
        b_in_data   = 24'h11;
        #1 chk("t3 ready c1", b_in_ready, 1);
        @(posedge clk); #1;
        b_in_data = 24'h22;
        #1 chk("t3 ready c2", b_in_ready, 1);
        @(posedge clk); #1;
        b_in_data = 24'h33;
        #1 chk("t3 ready c3", b_in_ready, 0);
        @(posedge clk); #1;
        chk("t3 ready c4", b_in_ready, 0);
        chk("t3 held valid", b_out_valid, 1);
        chk("t3 held data", b_out_data, 8'h11);
        b_out_ready = 1'b1;
        #1 chk("t3 ready release", b_in_ready, 1);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        chk("t3 out2", b_out_data, 8'h22);
        @(posedge clk); #1;
        chk("t3 out3", b_out_data, 8'h33);
        @(posedge clk); #1;
        chk("t3 empty", b_out_valid, 0);

        // Full pipe streaming at one beat per cycle
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("t4 xfer start", b_xfer, 0);
        b_out_ready = 1'b0;
        b_in_op     = OP_PASS;
        b_in_valid  = 1'b1;
        b_in_data   = 24'd0;
        @(posedge clk); #1;
        b_in_data = 24'd1;
        @(posedge clk); #1;
        b_out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            b_in_data = 24'(c + 2);
            #1;
            chk("t4 in_ready", b_in_ready, 1);
            chk("t4 out_valid", b_out_valid, 1);
            chk("t4 order", b_out_data, 32'(c));
            @(posedge clk); #1;
        end
        chk("t4 xfer20", b_xfer, 20);
        b_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("t4 xfer drained", b_xfer, 22);

        // Asynchronous reset with two beats in flight
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_data   = 24'hA1;
        @(posedge clk); #1;
        b_in_data = 24'hA2;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        chk("t5 inflight valid", b_out_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("t5 async valid", b_out_valid, 0);
        chk("t5 async xfer", b_xfer, 0);
        chk("t5 async data", b_out_data, 0);
        @(posedge clk); #1 rst = 1'b0;
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_op     = OP_PASS;
        b_in_data   = 24'h5A;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        chk("t5 lat early", b_out_valid, 0);
        @(posedge clk); #1;
        chk("t5 new valid", b_out_valid, 1);
        chk("t5 new data", b_out_data, 8'h5A);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("t5 no ghost", b_out_valid, 0);
        end

        // Narrow counter wrap on C
        c_out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            c_in_valid = 1'b1;
            c_in_op    = 3'(i);
            c_in_data  = 24'($urandom);
            @(posedge clk); #1;
        end
        c_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("t6 wrap17", c_xfer, 1);

        // Random-stall stream on C
        sent   = 0;
        budget = 0;
        fired  = 1'b0;
        while (sent < 10000 && budget < 60000) begin
            if (!c_in_valid || fired) begin
                c_in_valid = ($urandom_range(0, 3) != 0);
                c_in_op    = 3'($urandom_range(0, 7));
                c_in_data  = 24'($urandom);
            end
            c_out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            fired = c_in_valid && c_in_ready;
            if (fired) sent++;
            @(posedge clk); #1;
            budget++;
        end
        chk("t6 stream budget", 32'(sent), 10000);
        c_in_valid  = 1'b0;
        c_out_ready = 1'b1;
        for (int i = 0; i < 20 && mq[2].size() > 0; i++) begin
            @(posedge clk); #1;
        end
        chk("t6 drained", 32'(mq[2].size()), 0);
        chk("t6 wrap total", c_xfer, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
